// File: rtl/arch_defs_pkg.sv
// rtl/arch_defs_pkg.sv - SAP-2 control types: opcodes, FSM states, control word layout
package arch_defs_pkg;

   localparam int OPCODE_WIDTH_DEF = 4;
   localparam int FLAG_COUNT_DEF   = 3;
   localparam int MAX_STEPS_DEF    = 8;

   localparam int FLAG_C = 0;
   localparam int FLAG_Z = 1;
   localparam int FLAG_N = 2;

   typedef logic [OPCODE_WIDTH_DEF-1:0] opcode_t;

   localparam opcode_t OP_NOP = 4'h0;
   localparam opcode_t OP_LDA = 4'h1;
   localparam opcode_t OP_ADD = 4'h2;
   localparam opcode_t OP_SUB = 4'h3;
   localparam opcode_t OP_STA = 4'h4;
   localparam opcode_t OP_JMP = 4'h6;
   localparam opcode_t OP_JC  = 4'h7;
   localparam opcode_t OP_JZ  = 4'h8;
   localparam opcode_t OP_JN  = 4'h9;
   localparam opcode_t OP_OVF = 4'hE;
   localparam opcode_t OP_HLT = 4'hF;

   typedef enum logic [2:0] {
      S_RESET    = 3'd0,
      S_FETCH_0  = 3'd1,
      S_FETCH_1  = 3'd2,
      S_DECODE_0 = 3'd3,
      S_EXECUTE  = 3'd4,
      S_WAIT     = 3'd5,
      S_HALT     = 3'd6
   } fsm_state_t;

   typedef struct packed {
      logic halt;
      logic oe_pc;
      logic load_mar;
      logic oe_ram;
      logic load_ram;
      logic load_ir;
      logic pc_enable;
      logic oe_ir;
      logic load_a;
      logic oe_a;
      logic load_b;
      logic alu_sub;
      logic oe_alu;
      logic load_flags;
      logic load_pc;
      logic check_carry;
      logic check_zero;
      logic check_negative;
      logic last_step;
   } control_word_t;

endpackage

// File: rtl/microcode_rom.sv
// rtl/microcode_rom.sv - combinational execute-step table indexed by opcode and microstep
module microcode_rom
   import arch_defs_pkg::*;
#(
   parameter int STEP_W = 3
) (
   input  opcode_t             opcode,
   input  logic [STEP_W-1:0]   microstep,
   output control_word_t       word
);

   logic step0;
   logic step1;
   logic step2;

   assign step0 = (microstep == STEP_W'(0));
   assign step1 = (microstep == STEP_W'(1));
   assign step2 = (microstep == STEP_W'(2));

   // Any step not listed below is an empty word that ends the instruction.
   always_comb begin
      word           = '0;
      word.last_step = 1'b1;
      case (opcode)
         OP_LDA: begin
            if (step0) begin
               word.oe_ir = 1'b1; word.load_mar = 1'b1; word.last_step = 1'b0;
            end else if (step1) begin
               word.oe_ram = 1'b1; word.load_a = 1'b1; word.load_flags = 1'b1;
            end
         end
         OP_ADD, OP_SUB: begin
            if (step0) begin
               word.oe_ir = 1'b1; word.load_mar = 1'b1; word.last_step = 1'b0;
            end else if (step1) begin
               word.oe_ram = 1'b1; word.load_b = 1'b1; word.last_step = 1'b0;
            end else if (step2) begin
               word.oe_alu = 1'b1; word.load_a = 1'b1; word.load_flags = 1'b1;
               word.alu_sub = (opcode == OP_SUB);
            end
         end
         OP_STA: begin
            if (step0) begin
               word.oe_ir = 1'b1; word.load_mar = 1'b1; word.last_step = 1'b0;
            end else if (step1) begin
               word.oe_a = 1'b1; word.load_ram = 1'b1;
            end
         end
         OP_JMP, OP_JC, OP_JZ, OP_JN: begin
            if (step0) begin
               word.oe_ir          = 1'b1;
               word.load_pc        = 1'b1;
               word.check_carry    = (opcode == OP_JC);
               word.check_zero     = (opcode == OP_JZ);
               word.check_negative = (opcode == OP_JN);
            end
         end
         OP_OVF: begin
            word.oe_a      = 1'b1;
            word.last_step = 1'b0;
         end
         OP_HLT: begin
            if (step0) word.halt = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/microcode_sequencer.sv
// rtl/microcode_sequencer.sv - fetch/decode/execute control FSM with memory waits, jump masking and single-step
module microcode_sequencer
   import arch_defs_pkg::*;
#(
   parameter int OPCODE_WIDTH = OPCODE_WIDTH_DEF,
   parameter int FLAG_COUNT   = FLAG_COUNT_DEF,
   parameter int MAX_STEPS    = MAX_STEPS_DEF,
   localparam int STEP_W      = $clog2(MAX_STEPS)
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [OPCODE_WIDTH-1:0] opcode,
   input  logic [FLAG_COUNT-1:0]   flags,
   input  logic                    mem_ready,
   input  logic                    step_mode,
   input  logic                    step_req,
   output control_word_t           ctrl_word,
   output fsm_state_t              state,
   output logic [STEP_W-1:0]       microstep,
   output logic                    halted,
   output logic                    instr_done,
   output logic                    step_overflow
);

   localparam logic [STEP_W-1:0] LAST_STEP_IDX = STEP_W'(MAX_STEPS - 1);

   control_word_t     rom_word;
   fsm_state_t        state_nxt;
   logic [STEP_W-1:0] microstep_nxt;
   logic              overflow_nxt;
   logic              step_req_q;
   logic              step_rise;
   logic              jump_blocked;
   logic              mem_wait;
   logic              forced_end;
   logic              exec_end;

   microcode_rom #(
      .STEP_W (STEP_W)
   ) u_rom (
      .opcode    (opcode_t'(opcode)),
      .microstep (microstep),
      .word      (rom_word)
   );

   assign step_rise    = step_req && !step_req_q;
   assign halted       = (state == S_HALT);
   assign jump_blocked = (rom_word.check_carry    && !flags[FLAG_C]) ||
                         (rom_word.check_zero     && !flags[FLAG_Z]) ||
                         (rom_word.check_negative && !flags[FLAG_N]);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= S_RESET;
         microstep     <= '0;
         step_overflow <= 1'b0;
         step_req_q    <= 1'b0;
      end else begin
         state         <= state_nxt;
         microstep     <= microstep_nxt;
         step_overflow <= overflow_nxt;
         step_req_q    <= step_req;
      end
   end

   always_comb begin
      ctrl_word     = '0;
      instr_done    = 1'b0;
      state_nxt     = state;
      microstep_nxt = microstep;
      overflow_nxt  = step_overflow;
      mem_wait      = 1'b0;
      forced_end    = 1'b0;
      exec_end      = 1'b0;
      case (state)
         S_RESET:    state_nxt = S_FETCH_0;
         S_FETCH_0: begin
            ctrl_word.oe_pc    = 1'b1;
            ctrl_word.load_mar = 1'b1;
            state_nxt          = S_FETCH_1;
         end
         S_FETCH_1: begin
            ctrl_word.oe_ram = 1'b1;
            if (mem_ready) begin
               ctrl_word.load_ir   = 1'b1;
               ctrl_word.pc_enable = 1'b1;
               state_nxt           = S_DECODE_0;
            end
         end
         S_DECODE_0: state_nxt = S_EXECUTE;
         S_EXECUTE: begin
            forced_end = !rom_word.last_step && (microstep == LAST_STEP_IDX);
            exec_end   = rom_word.last_step || forced_end;
            mem_wait   = (rom_word.oe_ram || rom_word.load_ram) && !mem_ready;
            ctrl_word  = rom_word;
            if (jump_blocked) ctrl_word.load_pc = 1'b0;
            // While RAM is busy only the output enables stay up; nothing commits until ready.
            if (mem_wait) begin
               ctrl_word.load_mar   = 1'b0;
               ctrl_word.load_ram   = 1'b0;
               ctrl_word.load_ir    = 1'b0;
               ctrl_word.pc_enable  = 1'b0;
               ctrl_word.load_a     = 1'b0;
               ctrl_word.load_b     = 1'b0;
               ctrl_word.load_flags = 1'b0;
               ctrl_word.load_pc    = 1'b0;
               ctrl_word.halt       = 1'b0;
               ctrl_word.last_step  = 1'b0;
            end else begin
               instr_done = exec_end;
               if (forced_end) overflow_nxt = 1'b1;
               if (rom_word.halt)  state_nxt = S_HALT;
               else if (exec_end)  state_nxt = step_mode ? S_WAIT : S_FETCH_0;
               else                microstep_nxt = microstep + STEP_W'(1);
            end
         end
         S_WAIT: begin
            if (step_rise || !step_mode) state_nxt = S_FETCH_0;
         end
         S_HALT:  ;
         default: state_nxt = S_RESET;
      endcase
      if (state_nxt != S_EXECUTE) microstep_nxt = '0;
   end

endmodule
